// File: rtl/key_action_decoder.sv
// key_action_decoder
// Classifies debounced key gestures into short press, double click, long
// press and auto-repeat, timed by an external millisecond tick enable.
//
// Ports:
//   CLK          system clock
//   nRST         asynchronous active-low reset
//   TICK         one-cycle timing enable (1 kHz nominal)
//   KEY_FLAG     one-cycle pulse on each debounced key edge
//   KEY_STATE    debounced level, 0 = pressed, valid with KEY_FLAG
//   SHORT_PRESS  one-cycle pulse, single short click
//   DOUBLE_CLICK one-cycle pulse, two clicks inside the window
//   LONG_PRESS   one-cycle pulse when the hold reaches LONG_MS ticks
//   REPEAT       one-cycle pulse every REPEAT_MS ticks while held long
//   HELD         level, 1 while the key is considered down
module key_action_decoder #(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DCLICK_MS = 300,
  parameter bit DCLICK_EN = 1'b1,
  parameter int CNT_W     = 11
) (
  input  logic CLK,
  input  logic nRST,
  input  logic TICK,
  input  logic KEY_FLAG,
  input  logic KEY_STATE,
  output logic SHORT_PRESS,
  output logic DOUBLE_CLICK,
  output logic LONG_PRESS,
  output logic REPEAT,
  output logic HELD
);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESSED      = 3'd1,
    LONG_HELD    = 3'd2,
    WAIT_SECOND  = 3'd3,
    SECOND_PRESS = 3'd4
  } state_t;

  // A threshold N is reached on the Nth tick after entry, i.e. when the
  // counter still holds N-1 and TICK is high.
  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_MS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, dbl_d, long_d, rep_d, held_d;
  logic             press_ev, rel_ev;
  logic             long_hit, rep_hit, dclick_hit;
  logic             cnt_clr;

  assign press_ev   = KEY_FLAG & ~KEY_STATE;
  assign rel_ev     = KEY_FLAG &  KEY_STATE;
  assign long_hit   = TICK && (cnt_q == LONG_LAST);
  assign rep_hit    = TICK && (cnt_q == REPEAT_LAST);
  assign dclick_hit = TICK && (cnt_q == DCLICK_LAST);

  // Next-state and pulse decode. Key events are tested before timer hits
  // so that an edge landing on a threshold tick drops the timer action.
  always_comb begin
    state_d = state_q;
    short_d = 1'b0;
    dbl_d   = 1'b0;
    long_d  = 1'b0;
    rep_d   = 1'b0;
    cnt_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (press_ev) state_d = PRESSED;
      end
      PRESSED: begin
        if (rel_ev) begin
          if (DCLICK_EN) begin
            state_d = WAIT_SECOND;
          end else begin
            short_d = 1'b1;
            state_d = IDLE;
          end
        end else if (long_hit) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      LONG_HELD: begin
        if (rel_ev) begin
          state_d = IDLE;
        end else if (rep_hit) begin
          rep_d   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      WAIT_SECOND: begin
        if (press_ev) begin
          state_d = SECOND_PRESS;
        end else if (dclick_hit) begin
          short_d = 1'b1;
          state_d = IDLE;
        end
      end
      SECOND_PRESS: begin
        if (rel_ev) begin
          dbl_d   = 1'b1;
          state_d = IDLE;
        end else if (long_hit) begin
          // Hold on the second click turns into a long press; the first
          // click is dropped silently.
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counter restarts on every state change and on each repeat; it is held
  // at zero in IDLE so it cannot free-run there.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_d != state_q) || cnt_clr || (state_q == IDLE)) begin
      cnt_d = '0;
    end else if (TICK) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign held_d = (state_d == PRESSED) || (state_d == LONG_HELD) ||
                  (state_d == SECOND_PRESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      SHORT_PRESS  <= 1'b0;
      DOUBLE_CLICK <= 1'b0;
      LONG_PRESS   <= 1'b0;
      REPEAT       <= 1'b0;
      HELD         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      SHORT_PRESS  <= short_d;
      DOUBLE_CLICK <= dbl_d;
      LONG_PRESS   <= long_d;
      REPEAT       <= rep_d;
      HELD         <= held_d;
    end
  end

endmodule

// File: tb/tb_key_action_decoder.sv
// Bench for key_action_decoder: instance A with double-click detection,
// instance B without. Expected pulses (edge index + kind) are queued when
// stimulus is driven and matched as the DUT outputs pulse.
module tb_key_action_decoder;

  localparam int K_SHORT = 1, K_DBL = 2, K_LONG = 3, K_REP = 4;

  logic CLK = 1'b0;
  logic nRST, TICK;
  logic KEY_FLAG, KEY_STATE, KEY_FLAG_B, KEY_STATE_B;
  logic SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT, HELD;
  logic SHORT_B, DOUBLE_B, LONG_B, REPEAT_B, HELD_B;

  int edge_cnt = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {int e; int k;} ev_t;
  ev_t qa[$];
  ev_t qb[$];

  key_action_decoder #(.LONG_MS(10), .REPEAT_MS(4), .DCLICK_MS(5),
                       .DCLICK_EN(1'b1), .CNT_W(11)) dut_a (
    .CLK(CLK), .nRST(nRST), .TICK(TICK),
    .KEY_FLAG(KEY_FLAG), .KEY_STATE(KEY_STATE),
    .SHORT_PRESS(SHORT_PRESS), .DOUBLE_CLICK(DOUBLE_CLICK),
    .LONG_PRESS(LONG_PRESS), .REPEAT(REPEAT), .HELD(HELD)
  );

  key_action_decoder #(.LONG_MS(10), .REPEAT_MS(4), .DCLICK_MS(5),
                       .DCLICK_EN(1'b0), .CNT_W(11)) dut_b (
    .CLK(CLK), .nRST(nRST), .TICK(TICK),
    .KEY_FLAG(KEY_FLAG_B), .KEY_STATE(KEY_STATE_B),
    .SHORT_PRESS(SHORT_B), .DOUBLE_CLICK(DOUBLE_B),
    .LONG_PRESS(LONG_B), .REPEAT(REPEAT_B), .HELD(HELD_B)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d (edge %0d)",
               tag, obs, exp, edge_cnt);
    end
  endtask

  // TICK is sampled high on every edge index that is a multiple of 4.
  initial begin
    TICK = 1'b0;
    forever begin
      @(negedge CLK);
      TICK = ((edge_cnt + 1) % 4 == 0);
    end
  end

  // Edge index of the nth tick strictly after edge e.
  function automatic int nth_tick(input int e, input int n);
    return (e / 4 + n) * 4;
  endfunction

  // Present a key edge so that it is sampled on edge index e.
  task automatic key_at(input int e, input logic st, input bit b);
    if (edge_cnt >= e) check("late_stim", edge_cnt, e - 1);
    while (edge_cnt < e - 1) @(negedge CLK);
    if (b) begin KEY_FLAG_B = 1'b1; KEY_STATE_B = st; end
    else   begin KEY_FLAG   = 1'b1; KEY_STATE   = st; end
    @(negedge CLK);
    KEY_FLAG   = 1'b0;
    KEY_FLAG_B = 1'b0;
  endtask

  task automatic wait_edge(input int e);
    while (edge_cnt < e) @(negedge CLK);
  endtask

  function automatic int pulse_code(input logic s, input logic d,
                                    input logic l, input logic r);
    if (s) return K_SHORT;
    if (d) return K_DBL;
    if (l) return K_LONG;
    if (r) return K_REP;
    return 0;
  endfunction

  // Output monitor: every pulse must match the head of its queue.
  initial begin
    int n, code;
    ev_t ev;
    forever begin
      @(negedge CLK);
      n = int'(SHORT_PRESS) + int'(DOUBLE_CLICK) + int'(LONG_PRESS) + int'(REPEAT);
      if (n > 0) begin
        check("onehot_a", n, 1);
        code = pulse_code(SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT);
        if (qa.size() == 0) check("unexpected_a", code, 0);
        else begin
          ev = qa.pop_front();
          check("kind_a", code, ev.k);
          check("edge_a", edge_cnt, ev.e);
        end
      end
      n = int'(SHORT_B) + int'(DOUBLE_B) + int'(LONG_B) + int'(REPEAT_B);
      if (n > 0) begin
        check("onehot_b", n, 1);
        code = pulse_code(SHORT_B, DOUBLE_B, LONG_B, REPEAT_B);
        if (qb.size() == 0) check("unexpected_b", code, 0);
        else begin
          ev = qb.pop_front();
          check("kind_b", code, ev.k);
          check("edge_b", edge_cnt, ev.e);
        end
      end
    end
  end

  initial begin
    int p, r, r1, p2, r2, l;
    nRST = 1'b0;
    KEY_FLAG = 1'b0; KEY_STATE = 1'b1;
    KEY_FLAG_B = 1'b0; KEY_STATE_B = 1'b1;
    repeat (2) @(negedge CLK);
    check("rst_held_a", HELD, 0);
    check("rst_pulses_a", {SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT}, 0);
    check("rst_held_b", HELD_B, 0);
    check("rst_pulses_b", {SHORT_B, DOUBLE_B, LONG_B, REPEAT_B}, 0);
    nRST = 1'b1;
    @(negedge CLK);

    // Short press: release after 3 ticks, no second press.
    p = edge_cnt + 2;
    key_at(p, 1'b0, 0);
    check("t1_held_press", HELD, 1);
    r = nth_tick(p, 3) + 1;
    qa.push_back('{nth_tick(r, 5), K_SHORT});
    key_at(r, 1'b1, 0);
    check("t1_held_release", HELD, 0);
    wait_edge(nth_tick(r, 5) + 3);

    // Double click.
    p = edge_cnt + 2;
    key_at(p, 1'b0, 0);
    r1 = nth_tick(p, 2) + 1;
    key_at(r1, 1'b1, 0);
    check("t2_held_gap", HELD, 0);
    p2 = nth_tick(r1, 2) + 1;
    key_at(p2, 1'b0, 0);
    check("t2_held_second", HELD, 1);
    r2 = nth_tick(p2, 2) + 1;
    qa.push_back('{r2, K_DBL});
    key_at(r2, 1'b1, 0);
    wait_edge(nth_tick(r2, 8));

    // Long press with three repeats, then release.
    p = edge_cnt + 2;
    qa.push_back('{nth_tick(p, 10), K_LONG});
    qa.push_back('{nth_tick(p, 14), K_REP});
    qa.push_back('{nth_tick(p, 18), K_REP});
    qa.push_back('{nth_tick(p, 22), K_REP});
    key_at(p, 1'b0, 0);
    r = nth_tick(p, 22) + 1;
    key_at(r, 1'b1, 0);
    check("t3_held_release", HELD, 0);
    wait_edge(nth_tick(r, 8));

    // Release on the 10th tick: key event wins over the long threshold.
    p = edge_cnt + 2;
    r = nth_tick(p, 10);
    qa.push_back('{nth_tick(r, 5), K_SHORT});
    key_at(p, 1'b0, 0);
    key_at(r, 1'b1, 0);
    wait_edge(nth_tick(r, 8));

    // Reset while in LONG_HELD, then a clean short press.
    p = edge_cnt + 2;
    l = nth_tick(p, 10);
    qa.push_back('{l, K_LONG});
    key_at(p, 1'b0, 0);
    wait_edge(l + 3);
    check("t5_held_long", HELD, 1);
    nRST = 1'b0;
    @(negedge CLK);
    check("t5_rst_held", HELD, 0);
    check("t5_rst_pulses", {SHORT_PRESS, DOUBLE_CLICK, LONG_PRESS, REPEAT}, 0);
    nRST = 1'b1;
    @(negedge CLK);
    p = edge_cnt + 2;
    key_at(p, 1'b0, 0);
    r = nth_tick(p, 1) + 1;
    qa.push_back('{nth_tick(r, 5), K_SHORT});
    key_at(r, 1'b1, 0);
    wait_edge(nth_tick(r, 8));

    // No double-click detection: SHORT_PRESS right after release.
    p = edge_cnt + 2;
    key_at(p, 1'b0, 1);
    check("t6_held_b", HELD_B, 1);
    r = nth_tick(p, 1) + 1;
    qb.push_back('{r, K_SHORT});
    key_at(r, 1'b1, 1);
    wait_edge(r + 5);
    // Spurious releases in IDLE on both instances.
    key_at(edge_cnt + 2, 1'b1, 1);
    key_at(edge_cnt + 2, 1'b1, 0);
    wait_edge(nth_tick(edge_cnt, 8));
    check("t6_held_b_idle", HELD_B, 0);

    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_action_decoder.md
Name: key_action_decoder

Overview:
- Consumes the debounced key event stream (one-cycle KEY_FLAG pulse plus KEY_STATE level, 0 = pressed) from the key debouncer.
- Classifies each key gesture as short press, double click, long press, or auto-repeat while held.
- Times gestures with an external millisecond tick enable from the shared clock divider, so it needs no private prescaler.
- Feeds the clock's time-setting / mode control logic.

Parameters:
- LONG_MS, 1000, hold duration in ticks before LONG_PRESS fires.
- REPEAT_MS, 200, tick period of REPEAT pulses after LONG_PRESS.
- DCLICK_MS, 300, window in ticks after the first release in which a second press makes a double click.
- DCLICK_EN, 1, 1 = double-click detection on; 0 = SHORT_PRESS fires on release.
- CNT_W, 11, tick counter width. Must satisfy 2^CNT_W > max(LONG_MS, REPEAT_MS, DCLICK_MS).

Ports:
- CLK  input  1  system clock.
- nRST  input  1  asynchronous active-low reset.
- TICK  input  1  one-cycle enable, 1 kHz nominal, from the divider.
- KEY_FLAG  input  1  one-cycle pulse on each debounced edge.
- KEY_STATE  input  1  debounced level, 0 = pressed, valid when KEY_FLAG = 1.
- SHORT_PRESS  output  1  one-cycle pulse, single short click.
- DOUBLE_CLICK  output  1  one-cycle pulse, two clicks within the window.
- LONG_PRESS  output  1  one-cycle pulse when the hold reaches LONG_MS.
- REPEAT  output  1  one-cycle pulse every REPEAT_MS while the long hold continues.
- HELD  output  1  level, 1 while the key is considered down.

Behaviour:
- Clock, reset and outputs:
  - Reset: nRST asynchronous, active-low; clock CLK.
  - On reset, all pulse outputs are 0, HELD = 0, state = IDLE, counter = 0.
  - All outputs are registered.
  - Pulses assert the cycle after the triggering KEY_FLAG or TICK cycle, for exactly one cycle.
  - At most one pulse output is high in any cycle.
- Input events:
  - press_ev = KEY_FLAG & ~KEY_STATE.
  - rel_ev = KEY_FLAG & KEY_STATE.
- Counter:
  - Cleared to 0 on every state entry.
  - Increments by 1 on TICK otherwise.
  - A threshold N is "reached" on a cycle where TICK = 1 and counter == N-1, i.e. the Nth tick after entry.
  - The counter never wraps within a state: every state leaves or clears at its threshold.
- States:
  - IDLE:
    - press_ev -> PRESSED.
    - rel_ev ignored.
    - TICK ignored.
  - PRESSED (HELD = 1):
    - rel_ev with DCLICK_EN = 1 -> WAIT_SECOND.
    - rel_ev with DCLICK_EN = 0 -> pulse SHORT_PRESS, -> IDLE.
    - LONG_MS reached -> pulse LONG_PRESS, -> LONG_HELD.
  - LONG_HELD (HELD = 1):
    - REPEAT_MS reached -> pulse REPEAT, counter cleared, stay in LONG_HELD.
    - rel_ev -> IDLE, no further pulse.
  - WAIT_SECOND (HELD = 0):
    - press_ev -> SECOND_PRESS.
    - DCLICK_MS reached -> pulse SHORT_PRESS, -> IDLE.
  - SECOND_PRESS (HELD = 1):
    - rel_ev -> pulse DOUBLE_CLICK, -> IDLE.
    - LONG_MS reached -> pulse LONG_PRESS, -> LONG_HELD; the first click is discarded and no SHORT_PRESS is issued.
  - Any unencoded state -> IDLE, outputs 0.
- Simultaneous events:
  - If a key event and a threshold-reaching TICK occur in the same cycle, the key event wins and the timer action is dropped.
  - Example: release on the LONG_MS tick gives a short/double path, not LONG_PRESS.
- Redundant events:
  - A press_ev while already in a held state is ignored.
  - A rel_ev in IDLE or WAIT_SECOND is ignored.
- Reset mid-gesture: returns to IDLE with no pulse; the next gesture starts cleanly.
- TICK held high continuously is legal: the counter then advances once per CLK.

Test Plan (LONG_MS=10, REPEAT_MS=4, DCLICK_MS=5, DCLICK_EN=1, TICK every 4 CLK):
- Press, release after 3 ticks, no further press -> SHORT_PRESS pulses once, 1 cycle after the 5th tick following release. No other pulses. HELD 1 during the press only.
- Press, release after 2 ticks, re-press after 2 ticks, release after 2 ticks -> DOUBLE_CLICK pulses the cycle after the second rel_ev. SHORT_PRESS never fires.
- Press and hold 22 ticks -> LONG_PRESS after tick 10, REPEAT after ticks 14, 18 and 22 (4 pulses total). Release -> IDLE, no SHORT_PRESS.
- Release coinciding with the 10th tick -> no LONG_PRESS. SHORT_PRESS fires 5 ticks later.
- Assert nRST low while in LONG_HELD, then release it -> all outputs 0. A 1-tick press/release then yields SHORT_PRESS after 5 ticks.
- With DCLICK_EN=0, press/release after 1 tick -> SHORT_PRESS 1 cycle after rel_ev. A spurious rel_ev in IDLE -> no output.
